// File: rtl/tone_pkg.sv
// Shared note constants, band table, nominal tone periods and the period classifier.
// Also holds the tone player's phase-accumulator steps so both sides share one source.
package tone_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEASURE  = 2'd1,
        ST_CLASSIFY = 2'd2
    } state_e;

    typedef logic [47:0] period_t;

    localparam logic [3:0] NOTE_NONE = 4'd0;
    localparam logic [3:0] NOTE_C    = 4'd1;
    localparam logic [3:0] NOTE_D    = 4'd2;
    localparam logic [3:0] NOTE_E    = 4'd3;
    localparam logic [3:0] NOTE_FS   = 4'd4;
    localparam logic [3:0] NOTE_G    = 4'd5;
    localparam logic [3:0] NOTE_A    = 4'd6;
    localparam logic [3:0] NOTE_B    = 4'd7;
    localparam logic [3:0] NOTE_D5   = 4'd8;

    // Index i holds the band for note i+1; lower bound inclusive, upper exclusive.
    localparam period_t BAND_LO [8] = '{48'd361368, 48'd321950, 48'd286829, 48'd262692,
                                        48'd241189, 48'd214875, 48'd186372, 48'd165158};
    localparam period_t BAND_HI [8] = '{48'd393682, 48'd361368, 48'd321950, 48'd286829,
                                        48'd262692, 48'd241189, 48'd214875, 48'd186372};

    localparam period_t NOM_PERIOD [8] = '{48'd382216, 48'd340519, 48'd303381, 48'd270277,
                                           48'd255106, 48'd227271, 48'd202478, 48'd170266};

    // Player steps for a 32-bit phase accumulator: one wrap per nominal period.
    localparam int TONE_ACC_W = 32;
    localparam logic [31:0] TONE_STEP [8] = '{
        32'((64'd1 << 32) / 64'd382216), 32'((64'd1 << 32) / 64'd340519),
        32'((64'd1 << 32) / 64'd303381), 32'((64'd1 << 32) / 64'd270277),
        32'((64'd1 << 32) / 64'd255106), 32'((64'd1 << 32) / 64'd227271),
        32'((64'd1 << 32) / 64'd202478), 32'((64'd1 << 32) / 64'd170266)};

    // scale right-shifts the whole table, for builds that decode proportionally faster tones.
    function automatic logic [3:0] classify(input period_t avg, input int unsigned scale);
        logic [3:0] idx;
        idx = NOTE_NONE;
        for (int i = 0; i < 8; i++) begin
            if ((avg >= (BAND_LO[i] >> scale)) && (avg < (BAND_HI[i] >> scale)))
                idx = 4'(i + 1);
        end
        return idx;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer plus history flop; flags a rising edge of an asynchronous input.
module edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d_in,
    output logic rise
);

    logic [2:0] sh_q, sh_d;

    always_comb sh_d = {sh_q[1:0], d_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sh_q <= '0;
        else        sh_q <= sh_d;
    end

    assign rise = sh_q[1] & ~sh_q[2];

endmodule

// File: rtl/tone_decoder.sv
// Measures the averaged period of a square-wave tone and classifies it as a scale note.
//   state       | meaning
//   ST_IDLE     | silent, waiting for the first rising edge to start timing
//   ST_MEASURE  | summing 2^AVG_LOG2 periods into acc
//   ST_CLASSIFY | one cycle: classify acc average, apply two-window hysteresis
module tone_decoder
    import tone_pkg::*;
#(
    parameter int          AVG_LOG2    = 2,
    parameter int          CNT_W       = 20,
    parameter int unsigned TIMEOUT_CYC = 500000,
    parameter int unsigned SCALE_LOG2  = 0
) (
    input  logic       USER_CLK,
    input  logic       USER_RST_N,
    input  logic       TONE_IN,
    output logic [3:0] NOTE_IDX,
    output logic       NOTE_VALID,
    output logic       NOTE_NEW,
    output logic [7:0] GPIO_LED
);

    localparam int ACC_W = CNT_W + AVG_LOG2;
    localparam logic [AVG_LOG2-1:0] NPER_LAST = '1;

    logic                rise;
    state_e              state_q, state_d;
    logic [CNT_W-1:0]    pcnt_q, pcnt_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [AVG_LOG2-1:0] nper_q, nper_d;
    logic                sat_q, sat_d;
    logic [3:0]          note_q, note_d, prev_q, prev_d, cand;
    logic                new_q, new_d;
    logic                pcnt_max, timeout;
    period_t             avg;

    edge_sync u_sync (
        .clk   (USER_CLK),
        .rst_n (USER_RST_N),
        .d_in  (TONE_IN),
        .rise  (rise)
    );

    assign pcnt_max = &pcnt_q;
    assign timeout  = (state_q != ST_IDLE) && (32'(pcnt_q) >= TIMEOUT_CYC);

    always_ff @(posedge USER_CLK or negedge USER_RST_N) begin
        if (!USER_RST_N) begin
            state_q <= ST_IDLE;
            pcnt_q  <= '0;
            acc_q   <= '0;
            nper_q  <= '0;
            sat_q   <= 1'b0;
            note_q  <= NOTE_NONE;
            prev_q  <= NOTE_NONE;
            new_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            acc_q   <= acc_d;
            nper_q  <= nper_d;
            sat_q   <= sat_d;
            note_q  <= note_d;
            prev_q  <= prev_d;
            new_q   <= new_d;
        end
    end

    always_comb begin
        pcnt_d  = rise ? CNT_W'(1) : (pcnt_max ? pcnt_q : pcnt_q + CNT_W'(1));
        state_d = state_q;
        acc_d   = acc_q;
        nper_d  = nper_q;
        sat_d   = sat_q;
        if (timeout) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            nper_d  = '0;
            sat_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (rise) begin
                    state_d = ST_MEASURE;
                    acc_d   = '0;
                    nper_d  = '0;
                    sat_d   = 1'b0;
                end
                ST_MEASURE: if (rise) begin
                    acc_d = acc_q + ACC_W'(pcnt_q);
                    sat_d = sat_q | pcnt_max;
                    if (nper_q == NPER_LAST) state_d = ST_CLASSIFY;
                    else                     nper_d  = nper_q + AVG_LOG2'(1);
                end
                // The rise that closed the window also started this period.
                ST_CLASSIFY: begin
                    state_d = ST_MEASURE;
                    acc_d   = rise ? ACC_W'(pcnt_q) : '0;
                    nper_d  = rise ? AVG_LOG2'(1) : '0;
                    sat_d   = rise & pcnt_max;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        avg    = period_t'(acc_q >> AVG_LOG2);
        cand   = sat_q ? NOTE_NONE : classify(avg, SCALE_LOG2);
        note_d = note_q;
        prev_d = prev_q;
        new_d  = 1'b0;
        if (timeout) begin
            note_d = NOTE_NONE;
            prev_d = NOTE_NONE;
            new_d  = (note_q != NOTE_NONE);
        end else if (state_q == ST_CLASSIFY) begin
            prev_d = cand;
            if ((cand == prev_q) && (cand != note_q)) begin
                note_d = cand;
                new_d  = 1'b1;
            end
        end
    end

    assign NOTE_IDX   = note_q;
    assign NOTE_VALID = (note_q != NOTE_NONE);
    assign NOTE_NEW   = new_q;
    assign GPIO_LED   = (note_q == NOTE_NONE) ? 8'h00 : (8'h01 << (note_q - 4'd1));

endmodule

// File: tb/tb_tone_decoder.sv
// Directed bench for tone_decoder, run with the band table scaled down by 2^9 and a short timeout.
module tb_tone_decoder;

    localparam int TIMEOUT = 1000;
    // Scaled tone periods: C, E, G, A, B, D5 and one below every band.
    localparam int P_C = 746, P_E = 592, P_G = 498, P_A = 444, P_B = 395, P_D5 = 332, P_OOB = 293;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tone_in = 1'b0;
    logic [3:0] note_idx;
    logic       note_valid, note_new;
    logic [7:0] gpio_led;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int new_cnt = 0;
    int jit_k = 0;
    int last_rise = 0;
    int base;

    tone_decoder #(
        .AVG_LOG2    (2),
        .CNT_W       (20),
        .TIMEOUT_CYC (TIMEOUT),
        .SCALE_LOG2  (9)
    ) u_dut (
        .USER_CLK   (clk),
        .USER_RST_N (rst_n),
        .TONE_IN    (tone_in),
        .NOTE_IDX   (note_idx),
        .NOTE_VALID (note_valid),
        .NOTE_NEW   (note_new),
        .GPIO_LED   (gpio_led)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (note_new) new_cnt <= new_cnt + 1;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // n periods of the tone, each starting with its rising edge; jitter cycles -1, 0, +1.
    task automatic play(input int per, input int n);
        for (int k = 0; k < n; k++) begin
            int p;
            p = per + (jit_k % 3) - 1;
            jit_k++;
            tone_in   = 1'b1;
            last_rise = cyc;
            repeat (p / 2) tick();
            tone_in = 1'b0;
            repeat (p - p / 2) tick();
        end
    endtask

    task automatic do_reset();
        tone_in = 1'b0;
        rst_n   = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        base = new_cnt;
    endtask

    task automatic expect_note(input string tag, input logic [3:0] idx, input logic [7:0] led);
        expect_eq({tag, "_idx"}, 32'(note_idx), 32'(idx));
        expect_eq({tag, "_led"}, 32'(gpio_led), 32'(led));
        expect_eq({tag, "_valid"}, 32'(note_valid), 32'(idx != 4'd0));
    endtask

    initial begin
        int waited;
        #2;
        expect_note("reset", 4'd0, 8'h00);
        expect_eq("reset_new", 32'(note_new), 32'd0);

        // Steady C: nothing after 8 rises, note 1 after the 9th, then no more pulses.
        do_reset();
        play(P_C, 8);
        expect_note("c_8rises", 4'd0, 8'h00);
        play(P_C, 1);
        expect_note("c_9rises", 4'd1, 8'h01);
        expect_eq("c_pulses", 32'(new_cnt - base), 32'd1);
        play(P_C, 4);
        expect_note("c_steady", 4'd1, 8'h01);
        expect_eq("c_no_more", 32'(new_cnt - base), 32'd1);

        // E then D5 mid-window: mixed window ignored, two clean D5 windows needed.
        do_reset();
        play(P_E, 9);
        expect_note("e_lock", 4'd3, 8'h04);
        play(P_E, 2);
        play(P_D5, 9);
        expect_note("chg_pending", 4'd3, 8'h04);
        expect_eq("chg_pulses1", 32'(new_cnt - base), 32'd1);
        play(P_D5, 1);
        expect_note("chg_d5", 4'd8, 8'h80);
        expect_eq("chg_pulses2", 32'(new_cnt - base), 32'd2);

        // Out of band.
        do_reset();
        play(P_OOB, 12);
        expect_note("oob", 4'd0, 8'h00);
        expect_eq("oob_pulses", 32'(new_cnt - base), 32'd0);

        // Silence: valid drops exactly TIMEOUT+3 cycles after the last driven rise.
        do_reset();
        play(P_G, 9);
        expect_note("g_lock", 4'd5, 8'h10);
        waited = 0;
        while (note_valid && waited < 3 * TIMEOUT) begin
            tick();
            waited++;
        end
        expect_eq("sil_time", 32'(cyc - last_rise), 32'(TIMEOUT + 3));
        expect_eq("sil_new", 32'(note_new), 32'd1);
        expect_note("sil", 4'd0, 8'h00);
        tick();
        expect_eq("sil_pulses", 32'(new_cnt - base), 32'd2);
        play(P_G, 8);
        expect_note("sil_restart8", 4'd0, 8'h00);
        play(P_G, 1);
        expect_note("sil_restart9", 4'd5, 8'h10);

        // Asynchronous reset mid-window while A is displayed.
        do_reset();
        play(P_A, 9);
        expect_note("a_lock", 4'd6, 8'h20);
        play(P_A, 2);
        tone_in = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        expect_note("rst_async", 4'd0, 8'h00);
        expect_eq("rst_new", 32'(note_new), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        base = new_cnt;
        play(P_A, 8);
        expect_note("rst_restart8", 4'd0, 8'h00);
        play(P_A, 1);
        expect_note("rst_restart9", 4'd6, 8'h20);
        expect_eq("rst_pulses", 32'(new_cnt - base), 32'd1);

        // Hysteresis: one aligned A window between B windows changes nothing.
        do_reset();
        play(P_B, 12);
        expect_note("b_lock", 4'd7, 8'h40);
        play(P_A, 4);
        play(P_B, 1);
        expect_note("hyst_odd", 4'd7, 8'h40);
        play(P_B, 8);
        expect_note("hyst_end", 4'd7, 8'h40);
        expect_eq("hyst_pulses", 32'(new_cnt - base), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #(1_500_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
